iiitb_icg_ctrl: RTL and testbench
=================================

IIITB_ICG_CTRL -- requirements
Module: iiitb_icg_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 8, meaning consecutive idle cycles in RUN before gating; legal range 1..255.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2, meaning cycles gate_en is held before rdy asserts; legal range 1..255.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port global_en  input  1  1 = channels may run, 0 = gate every channel once not busy.
REQ-006 SHALL have port req  input  2  per-channel activity request (bit n = channel n).
REQ-007 SHALL have port busy  input  2  per-channel domain-busy indication; blocks gating.
REQ-008 SHALL have port gate_en  output  2  enable to the channel n clock-gate cell.
REQ-009 SHALL have port rdy  output  2  channel n gated clock stable and usable.
REQ-010 SHALL have port gated_cnt  output  2  number of channels currently in OFF (0..2).

Function
REQ-011 SHALL implement one FSM per channel with states OFF, WAKE, RUN, plus an 8-bit idle counter and an 8-bit wake counter per channel.
REQ-012 SHALL register all outputs: OFF -> gate_en=0, rdy=0; WAKE -> gate_en=1, rdy=0; RUN -> gate_en=1, rdy=1.
REQ-013 SHALL drive gated_cnt as the registered count of channels in OFF, consistent with the same-cycle state.
REQ-014 OFF -> WAKE SHALL occur on an edge where req[n]=1, global_en=1, and channel n holds the wake grant; wake counter cleared to 0.
REQ-015 SHALL permit at most one channel in WAKE at any time; no grant is issued while a channel is in WAKE or entering it.
REQ-016 When both channels are eligible for a grant in the same cycle, SHALL grant round-robin: pointer resets to channel 0 and moves to the other channel after each grant.
REQ-017 When only one channel is eligible, SHALL grant it regardless of the pointer, and the pointer SHALL then move to the other channel.
REQ-018 WAKE SHALL last exactly WAKE_CYCLES cycles, then go to RUN: rdy[n] rises WAKE_CYCLES edges after the edge where gate_en[n] rose.
REQ-019 WAKE SHALL ignore req, busy, and global_en; a wake always completes to RUN.
REQ-020 RUN idle counter SHALL increment each cycle with req[n]=0 and busy[n]=0, and clear to 0 in any cycle where req[n]=1 or busy[n]=1.
REQ-021 RUN -> OFF SHALL occur on the edge where the idle counter equals IDLE_CYCLES-1 and the channel is still idle, so gate_en falls IDLE_CYCLES edges after the last active cycle.
REQ-022 RUN with global_en=0 and busy[n]=0 SHALL go to OFF on the next edge, irrespective of req and the idle counter.
REQ-023 RUN with busy[n]=1 SHALL never go to OFF, for any global_en value.
REQ-024 On entering RUN, the idle counter SHALL be 0; counters SHALL saturate and never wrap.

Reset
REQ-025 While rst=1, SHALL force both channels to OFF, clear all counters, and set the round-robin pointer to channel 0.
REQ-026 While rst=1, SHALL drive gate_en=2'b00, rdy=2'b00, gated_cnt=2; these values appear immediately, without waiting for clk.
REQ-027 rst asserted mid-WAKE or mid-RUN SHALL abort the operation with no completion; after release, channels restart from OFF.
REQ-028 The first grant SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-029 Reset release, global_en=1, req=2'b01 held -> gate_en[0]=1 after edge 1; rdy[0]=1 after edge 3 (WAKE_CYCLES=2); channel 1 stays OFF; gated_cnt 2->1.
REQ-030 req=2'b11 from reset -> ch0 in WAKE cycles 1-2; ch1 gate_en rises after edge 3, rdy[1] after edge 5; gate_en never shows both rising on the same edge.
REQ-031 Ch0 in RUN, req[0] and busy[0] drop at edge k -> gate_en[0]=0 after edge k+8 (IDLE_CYCLES=8); a single req pulse at k+4 delays the fall to k+12.
REQ-032 Ch0 and ch1 in RUN, busy=2'b10, global_en=0 -> ch0 goes OFF next edge; ch1 stays RUN until busy[1]=0, then goes OFF the following edge; gated_cnt reaches 2.
REQ-033 rst pulsed asynchronously mid-WAKE of ch1 -> gate_en/rdy go to 00 before the next clk edge; after release, req=2'b11 grants ch0 first.
REQ-034 Both channels OFF, only ch1 requests twice in a row -> ch1 is granted each time; the pointer alternates correctly on the next simultaneous request.

Source files
------------

// File: rtl/iiitb_icg_ctrl.sv
// Two-channel clock-gate controller: per-channel OFF/WAKE/RUN FSM with
// idle-timeout gating and a single round-robin wake slot.
module iiitb_icg_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       global_en,
  input  logic [1:0] req,
  input  logic [1:0] busy,
  output logic [1:0] gate_en,
  output logic [1:0] rdy,
  output logic [1:0] gated_cnt
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [7:0] LP_ILAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] LP_WLAST = 8'(WAKE_CYCLES - 1);

  state_t     r_st   [2];
  logic [7:0] r_idle [2];
  logic [7:0] r_wcnt [2];
  logic       r_ptr;

  state_t     w_nst   [2];
  logic [7:0] w_nidle [2];
  logic [7:0] w_nwcnt [2];
  logic [1:0] w_elig;
  logic [1:0] w_gnt;
  logic       w_hold;
  logic [1:0] w_noff;

  // A wake finishing on this edge frees the slot for a same-edge grant.
  always_comb begin
    w_hold = 1'b0;
    w_elig = 2'b00;
    for (int n = 0; n < 2; n++) begin
      w_elig[n] = (r_st[n] == S_OFF) && req[n] && global_en;
      if (r_st[n] == S_WAKE && r_wcnt[n] != LP_WLAST)
        w_hold = 1'b1;
    end
    w_gnt = 2'b00;
    if (!w_hold) begin
      if (&w_elig)
        w_gnt = r_ptr ? 2'b10 : 2'b01;
      else
        w_gnt = w_elig;
    end
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_nst[n]   = r_st[n];
      w_nidle[n] = r_idle[n];
      w_nwcnt[n] = r_wcnt[n];
      unique case (r_st[n])
        S_OFF: begin
          if (w_gnt[n]) begin
            w_nst[n]   = S_WAKE;
            w_nwcnt[n] = 8'd0;
          end
        end
        S_WAKE: begin
          if (r_wcnt[n] == LP_WLAST) begin
            w_nst[n]   = S_RUN;
            w_nidle[n] = 8'd0;
          end else if (r_wcnt[n] != 8'hFF) begin
            w_nwcnt[n] = r_wcnt[n] + 8'd1;
          end
        end
        S_RUN: begin
          if (busy[n]) begin
            w_nidle[n] = 8'd0;
          end else if (!global_en) begin
            w_nst[n]   = S_OFF;
            w_nidle[n] = 8'd0;
          end else if (req[n]) begin
            w_nidle[n] = 8'd0;
          end else if (r_idle[n] == LP_ILAST) begin
            w_nst[n]   = S_OFF;
            w_nidle[n] = 8'd0;
          end else if (r_idle[n] != 8'hFF) begin
            w_nidle[n] = r_idle[n] + 8'd1;
          end
        end
        default: begin
          w_nst[n] = S_OFF;
        end
      endcase
    end
    w_noff = {1'b0, w_nst[0] == S_OFF}
           + {1'b0, w_nst[1] == S_OFF};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        r_st[n]   <= S_OFF;
        r_idle[n] <= 8'd0;
        r_wcnt[n] <= 8'd0;
      end
      r_ptr     <= 1'b0;
      gate_en   <= 2'b00;
      rdy       <= 2'b00;
      gated_cnt <= 2'd2;
    end else begin
      for (int n = 0; n < 2; n++) begin
        r_st[n]    <= w_nst[n];
        r_idle[n]  <= w_nidle[n];
        r_wcnt[n]  <= w_nwcnt[n];
        gate_en[n] <= (w_nst[n] != S_OFF);
        rdy[n]     <= (w_nst[n] == S_RUN);
      end
      if (|w_gnt)
        r_ptr <= w_gnt[0];
      gated_cnt <= w_noff;
    end
  end

endmodule

// File: tb/tb_iiitb_icg_ctrl.sv
// Directed bench for iiitb_icg_ctrl: vector table plus hand-written
// multi-cycle sequences for idle timeout, async reset and round-robin.
module tb_iiitb_icg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       global_en = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] busy = 2'b00;
  logic [1:0] gate_en;
  logic [1:0] rdy;
  logic [1:0] gated_cnt;

  iiitb_icg_ctrl #(
    .IDLE_CYCLES(8),
    .WAKE_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .global_en (global_en),
    .req       (req),
    .busy      (busy),
    .gate_en   (gate_en),
    .rdy       (rdy),
    .gated_cnt (gated_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  logic [1:0] prev_gate = 2'b00;

  typedef struct {
    bit         rs;
    logic [1:0] rq;
    logic [1:0] bz;
    logic       ge;
    logic [1:0] eg;
    logic [1:0] er;
    logic [1:0] ec;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [1:0] eg,
                     input logic [1:0] er, input logic [1:0] ec);
    n_tot++;
    if (gate_en === eg && rdy === er && gated_cnt === ec)
      n_pass++;
    else
      $display("FAIL %s: got gate=%b rdy=%b cnt=%0d, expected gate=%b rdy=%b cnt=%0d",
               nm, gate_en, rdy, gated_cnt, eg, er, ec);
  endtask

  // Every edge also confirms the two gates never rise together.
  task automatic step();
    @(posedge clk);
    #1;
    n_tot++;
    if ((gate_en & ~prev_gate) !== 2'b11)
      n_pass++;
    else
      $display("FAIL dual_rise: got gate=%b prev=%b, expected not both rising",
               gate_en, prev_gate);
    prev_gate = gate_en;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    busy = 2'b00;
    global_en = 1'b1;
    #1;
    chk("reset_async", 2'b00, 2'b00, 2'd2);
    @(negedge clk);
    rst = 1'b0;
    prev_gate = 2'b00;
  endtask

  initial begin
    tbl.push_back('{1, 2'b01, 2'b00, 1, 2'b01, 2'b00, 2'd1, "r29_e1"});
    tbl.push_back('{0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 2'd1, "r29_e2"});
    tbl.push_back('{0, 2'b01, 2'b00, 1, 2'b01, 2'b01, 2'd1, "r29_e3"});
    tbl.push_back('{0, 2'b11, 2'b00, 1, 2'b11, 2'b01, 2'd0, "r17_ch1_grant"});
    tbl.push_back('{0, 2'b11, 2'b00, 1, 2'b11, 2'b01, 2'd0, "r17_ch1_wake"});
    tbl.push_back('{0, 2'b11, 2'b00, 1, 2'b11, 2'b11, 2'd0, "r17_ch1_run"});
    tbl.push_back('{1, 2'b11, 2'b00, 1, 2'b01, 2'b00, 2'd1, "r30_e1"});
    tbl.push_back('{0, 2'b11, 2'b00, 1, 2'b01, 2'b00, 2'd1, "r30_e2"});
    tbl.push_back('{0, 2'b11, 2'b00, 1, 2'b11, 2'b01, 2'd0, "r30_e3"});
    tbl.push_back('{0, 2'b11, 2'b00, 1, 2'b11, 2'b01, 2'd0, "r30_e4"});
    tbl.push_back('{0, 2'b11, 2'b00, 1, 2'b11, 2'b11, 2'd0, "r30_e5"});
    tbl.push_back('{0, 2'b00, 2'b10, 0, 2'b10, 2'b10, 2'd1, "r32_ch0_off"});
    tbl.push_back('{0, 2'b00, 2'b10, 0, 2'b10, 2'b10, 2'd1, "r32_ch1_busy"});
    tbl.push_back('{0, 2'b00, 2'b10, 1, 2'b10, 2'b10, 2'd1, "r23_busy_ge1"});
    tbl.push_back('{0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'd2, "r32_all_off"});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rs)
        do_reset();
      req = tbl[i].rq;
      busy = tbl[i].bz;
      global_en = tbl[i].ge;
      step();
      chk(tbl[i].nm, tbl[i].eg, tbl[i].er, tbl[i].ec);
    end

    // idle timeout: plain fall at k+8, then a pulse at k+4 pushes it to k+12
    do_reset();
    req = 2'b01;
    repeat (4) step();
    req = 2'b00;
    repeat (7) step();
    chk("r31_on_k7", 2'b01, 2'b01, 2'd1);
    step();
    chk("r31_off_k8", 2'b00, 2'b00, 2'd2);
    req = 2'b01;
    repeat (4) step();
    req = 2'b00;
    repeat (3) step();
    req = 2'b01;
    step();
    req = 2'b00;
    repeat (4) step();
    chk("r31_pulse_on_k8", 2'b01, 2'b01, 2'd1);
    repeat (3) step();
    chk("r31_pulse_on_k11", 2'b01, 2'b01, 2'd1);
    step();
    chk("r31_pulse_off_k12", 2'b00, 2'b00, 2'd2);

    // async reset during ch1 wake
    do_reset();
    req = 2'b11;
    repeat (3) step();
    chk("r33_pre", 2'b11, 2'b01, 2'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("r33_async", 2'b00, 2'b00, 2'd2);
    rst = 1'b0;
    prev_gate = 2'b00;
    step();
    chk("r33_ch0_first", 2'b01, 2'b00, 2'd1);

    // lone ch1 grants, then pointer alternation
    do_reset();
    req = 2'b10;
    step();
    chk("r34_g1", 2'b10, 2'b00, 2'd1);
    repeat (2) step();
    chk("r34_g1_run", 2'b10, 2'b10, 2'd1);
    req = 2'b00;
    global_en = 1'b0;
    step();
    chk("r22_ge_off", 2'b00, 2'b00, 2'd2);
    req = 2'b10;
    global_en = 1'b1;
    step();
    chk("r34_g2", 2'b10, 2'b00, 2'd1);
    repeat (2) step();
    req = 2'b00;
    global_en = 1'b0;
    step();
    chk("r34_g2_off", 2'b00, 2'b00, 2'd2);
    req = 2'b11;
    global_en = 1'b1;
    step();
    chk("r34_rr_ch0", 2'b01, 2'b00, 2'd1);
    req = 2'b00;
    global_en = 1'b0;
    repeat (2) step();
    chk("r19_wake_ignores_ge", 2'b01, 2'b01, 2'd1);
    step();
    chk("r34_ch0_off", 2'b00, 2'b00, 2'd2);
    req = 2'b11;
    global_en = 1'b1;
    step();
    chk("r34_rr_ch1", 2'b10, 2'b00, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
